pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Fetch-side controller for program_counter_top. Drives its Run, PC_Sel and Program_Count_Imm.
//  Handles boot to a reset vector, sequential fetch, stall hold, branch redirect with a
//  counted flush window, halt/resume, and a stall watchdog.
//  Sits between the hazard/branch unit, the instruction-memory handshake and the PC.
// PARAMETERS
//  DWIDTH       32           PC / target width
//  RESET_VECTOR 32'h0000_0000 first fetch address loaded in BOOT
//  FLUSH_DEPTH  2            cycles Flush is held after a redirect (>=1)
//  WDOG_LIMIT   255          consecutive stalled RUN cycles before watchdog trips (>=1)
// PORTS
//  Clk_Core          in  1      core clock
//  Rst_Core_N        in  1      asynchronous active-low reset
//  Start             in  1      pulse: leave IDLE/HALT (IDLE->BOOT, HALT->RUN)
//  Halt_Req          in  1      request to stop fetching
//  Stall             in  1      hazard stall: hold PC
//  Imem_Ready        in  1      instruction memory accepts/returns a fetch this cycle
//  Branch_Taken      in  1      resolved taken branch/jump this cycle
//  Branch_Target     in  DWIDTH redirect address
//  Run               out 1      to PC: advance/load on this edge
//  PC_Sel            out 1      to PC: 0 = PC+4, 1 = Program_Count_Imm
//  Program_Count_Imm out DWIDTH to PC: load address (RESET_VECTOR or Branch_Target)
//  Fetch_Valid       out 1      instruction at current PC is accepted into decode
//  Flush             out 1      kill younger in-flight instructions
//  Wdog_Err          out 1      sticky watchdog error, cleared only by reset
//  Seq_State         out 3      encoded state, for debug
// BEHAVIOUR
//  Reset (async, any time, incl. mid-flush):
//   - state=IDLE; counters=0; Wdog_Err=0.
//   - All outputs 0; Program_Count_Imm=0.
//  Run/PC_Sel/Program_Count_Imm/Fetch_Valid are combinational from state+inputs, so the PC
//  updates on the same edge. Flush, Wdog_Err and state are registered.
//  States (Seq_State): IDLE=0 BOOT=1 RUN=2 FLUSH=3 HALT=4; unused codes -> IDLE.
//  IDLE:
//   - Run=0, Fetch_Valid=0.
//   - Start -> BOOT; other inputs ignored.
//  BOOT (1 cycle):
//   - Run=1, PC_Sel=1, Imm=RESET_VECTOR, Fetch_Valid=0.
//   - -> RUN unconditionally.
//  RUN, priority Branch_Taken > Halt_Req > Stall/Imem_Ready:
//   - Branch_Taken: Run=1, PC_Sel=1, Imm=Branch_Target, Fetch_Valid=0.
//     Redirect ignores Stall and Imem_Ready. Next cycle Flush=1, flush counter=FLUSH_DEPTH,
//     -> FLUSH.
//   - Halt_Req: Run=0, Fetch_Valid=0, -> HALT.
//   - else: Run=Fetch_Valid=Imem_Ready&~Stall, PC_Sel=0.
//  FLUSH:
//   - Flush=1, Fetch_Valid=0, Run=Imem_Ready, PC_Sel=0.
//   - Counter decrements each cycle; at 1 -> RUN, with Flush=0 in the next cycle.
//   - Branch_Taken and Halt_Req are ignored (they come from flushed instructions).
//  HALT:
//   - Run=0, PC held.
//   - Start (Halt_Req low) -> RUN, resuming at the held PC with no re-boot.
//   - Start with Halt_Req high stays in HALT.
//  Watchdog:
//   - Counts consecutive RUN cycles with Stall|~Imem_Ready and no branch.
//   - Clears on any advancing cycle or on leaving RUN; saturates.
//   - Reaching WDOG_LIMIT: Wdog_Err<=1, -> HALT.
//  Start while in BOOT/RUN/FLUSH: ignored.
//  Program_Count_Imm is 0 whenever PC_Sel=0.
// TESTING
//  1. Reset, Start pulse, Imem_Ready=1 -> BOOT 1 cycle with Imm=0; PC 0,4,8,... and
//     Fetch_Valid=1 from the first RUN cycle.
//  2. Stall=1 for 3 cycles at PC=0x10 -> Run=0, PC holds 0x10 for 3 cycles, then 0x14.
//  3. Branch_Taken with target 0x80 while Stall=1 -> PC=0x80 next edge; Flush=1 for exactly
//     FLUSH_DEPTH=2 cycles; a second branch in FLUSH is ignored.
//  4. Halt_Req with Branch_Taken same cycle -> branch wins, then FLUSH; Halt_Req in RUN ->
//     HALT, PC frozen; Start -> resumes at frozen PC+4 sequence.
//  5. WDOG_LIMIT=4, Imem_Ready=0 held -> Wdog_Err=1 after 4 RUN cycles, state=HALT,
//     sticky until reset.
//  6. Rst_Core_N low mid-FLUSH -> all outputs 0 immediately (async); state=IDLE; Flush=0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the hazard/branch/imem side and the PC.
// Ports: slave = pc_sequencer, master = environment driving the controls.
interface pc_sequencer_if #(
    parameter int unsigned DWIDTH = 32
);
    logic              Start;
    logic              Halt_Req;
    logic              Stall;
    logic              Imem_Ready;
    logic              Branch_Taken;
    logic [DWIDTH-1:0] Branch_Target;
    logic              Run;
    logic              PC_Sel;
    logic [DWIDTH-1:0] Program_Count_Imm;
    logic              Fetch_Valid;
    logic              Flush;
    logic              Wdog_Err;
    logic [2:0]        Seq_State;

    modport slave (
        input  Start, Halt_Req, Stall, Imem_Ready,
        input  Branch_Taken, Branch_Target,
        output Run, PC_Sel, Program_Count_Imm,
        output Fetch_Valid, Flush, Wdog_Err, Seq_State
    );

    modport master (
        output Start, Halt_Req, Stall, Imem_Ready,
        output Branch_Taken, Branch_Target,
        input  Run, PC_Sel, Program_Count_Imm,
        input  Fetch_Valid, Flush, Wdog_Err, Seq_State
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-side sequencer: boot, sequential fetch, stall, redirect+flush, halt, watchdog.
// Ports: Clk_Core, Rst_Core_N (async active-low), bus (pc_sequencer_if.slave).
module pc_sequencer #(
    parameter int unsigned       DWIDTH       = 32,
    parameter logic [DWIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned       FLUSH_DEPTH  = 2,
    parameter int unsigned       WDOG_LIMIT   = 255
) (
    input  logic          Clk_Core,
    input  logic          Rst_Core_N,
    pc_sequencer_if.slave bus
);
    localparam int unsigned FW = $clog2(FLUSH_DEPTH + 1);
    localparam int unsigned WW = $clog2(WDOG_LIMIT + 1);
    localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_DEPTH);
    localparam logic [WW-1:0] WDOG_LAST  = WW'(WDOG_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BOOT  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          flush_q, flush_d;
    logic          err_q, err_d;

    logic              advance;
    logic              run;
    logic              pc_sel;
    logic [DWIDTH-1:0] imm;
    logic              fetch_valid;

    assign advance = bus.Imem_Ready & ~bus.Stall;

    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            wdog_q  <= '0;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wdog_q  <= wdog_d;
            flush_q <= flush_d;
            err_q   <= err_d;
        end
    end

    // Watchdog count defaults to 0 so any non-stalled or non-RUN cycle clears it.
    always_comb begin
        state_d = state_q;
        fcnt_d  = '0;
        wdog_d  = '0;
        flush_d = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) state_d = S_BOOT;
            end
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (bus.Branch_Taken) begin
                    state_d = S_FLUSH;
                    fcnt_d  = FLUSH_INIT;
                    flush_d = 1'b1;
                end else if (bus.Halt_Req) begin
                    state_d = S_HALT;
                end else if (!advance) begin
                    if (wdog_q >= WDOG_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        wdog_d = wdog_q + WW'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (fcnt_q <= FW'(1)) begin
                    state_d = S_RUN;
                end else begin
                    fcnt_d  = fcnt_q - FW'(1);
                    flush_d = 1'b1;
                end
            end
            S_HALT: begin
                if (bus.Start && !bus.Halt_Req) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        run         = 1'b0;
        pc_sel      = 1'b0;
        imm         = '0;
        fetch_valid = 1'b0;
        case (state_q)
            S_BOOT: begin
                run    = 1'b1;
                pc_sel = 1'b1;
                imm    = RESET_VECTOR;
            end
            S_RUN: begin
                if (bus.Branch_Taken) begin
                    run    = 1'b1;
                    pc_sel = 1'b1;
                    imm    = bus.Branch_Target;
                end else if (!bus.Halt_Req) begin
                    run         = advance;
                    fetch_valid = advance;
                end
            end
            S_FLUSH: begin
                run = bus.Imem_Ready;
            end
            default: ;
        endcase
    end

    assign bus.Run               = run;
    assign bus.PC_Sel            = pc_sel;
    assign bus.Program_Count_Imm = imm;
    assign bus.Fetch_Valid       = fetch_valid;
    assign bus.Flush             = flush_q;
    assign bus.Wdog_Err          = err_q;
    assign bus.Seq_State         = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic
// against a behavioural model of the fetch sequencer and the PC it drives.
module tb_pc_sequencer;
    localparam int FD = 2;
    localparam int WL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.DWIDTH(32)) bus ();

    pc_sequencer #(
        .DWIDTH(32),
        .RESET_VECTOR(32'h0),
        .FLUSH_DEPTH(FD),
        .WDOG_LIMIT(WL)
    ) dut (
        .Clk_Core(clk),
        .Rst_Core_N(rst_n),
        .bus(bus)
    );

    // Model: mode 0 idle,1 boot,2 run,3 flush,4 halt
    int          m_mode, m_left, m_stuck;
    bit          m_err;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] dut_pc = 32'h0;
    logic        e_run, e_sel, e_fv;
    logic [31:0] e_imm;

    always_comb begin
        e_run = 1'b0;
        e_sel = 1'b0;
        e_imm = 32'h0;
        e_fv  = 1'b0;
        if (m_mode == 1) begin
            e_run = 1'b1;
            e_sel = 1'b1;
        end else if (m_mode == 2) begin
            if (bus.Branch_Taken) begin
                e_run = 1'b1;
                e_sel = 1'b1;
                e_imm = bus.Branch_Target;
            end else if (!bus.Halt_Req) begin
                e_run = bus.Imem_Ready && !bus.Stall;
                e_fv  = e_run;
            end
        end else if (m_mode == 3) begin
            e_run = bus.Imem_Ready;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= 0;
            m_left  <= 0;
            m_stuck <= 0;
            m_err   <= 1'b0;
        end else begin
            case (m_mode)
                0: if (bus.Start) m_mode <= 1;
                1: m_mode <= 2;
                2: begin
                    if (bus.Branch_Taken) begin
                        m_mode  <= 3;
                        m_left  <= FD;
                        m_stuck <= 0;
                    end else if (bus.Halt_Req) begin
                        m_mode  <= 4;
                        m_stuck <= 0;
                    end else if (bus.Imem_Ready && !bus.Stall) begin
                        m_stuck <= 0;
                    end else if (m_stuck + 1 >= WL) begin
                        m_err   <= 1'b1;
                        m_mode  <= 4;
                        m_stuck <= 0;
                    end else begin
                        m_stuck <= m_stuck + 1;
                    end
                end
                3: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_mode <= 2;
                end
                4: if (bus.Start && !bus.Halt_Req) m_mode <= 2;
                default: m_mode <= 0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (e_run) m_pc <= e_sel ? e_imm : m_pc + 32'd4;
        if (bus.Run) dut_pc <= bus.PC_Sel ? bus.Program_Count_Imm : dut_pc + 32'd4;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("run", 32'(bus.Run), 32'(e_run));
            chk("pc_sel", 32'(bus.PC_Sel), 32'(e_sel));
            chk("imm", bus.Program_Count_Imm, e_imm);
            chk("fetch_valid", 32'(bus.Fetch_Valid), 32'(e_fv));
            chk("flush", 32'(bus.Flush), 32'(m_mode == 3));
            chk("wdog_err", 32'(bus.Wdog_Err), 32'(m_err));
            chk("seq_state", 32'(bus.Seq_State), 32'(m_mode));
            chk("pc", dut_pc, m_pc);
        end
    end

    task automatic apply(input bit s, input bit h, input bit st, input bit r,
                         input bit b, input logic [31:0] t);
        bus.Start         = s;
        bus.Halt_Req      = h;
        bus.Stall         = st;
        bus.Imem_Ready    = r;
        bus.Branch_Taken  = b;
        bus.Branch_Target = t;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        apply(0, 0, 0, 0, 0, 0);
        chk("rst_state", 32'(bus.Seq_State), 0);
        chk("rst_run", 32'(bus.Run), 0);
        chk("rst_flush", 32'(bus.Flush), 0);
        chk("rst_err", 32'(bus.Wdog_Err), 0);
        chk("rst_imm", bus.Program_Count_Imm, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // boot and sequential fetch
        apply(1, 0, 0, 1, 0, 0);
        chk("idle_run", 32'(bus.Run), 0);
        tick();
        apply(0, 0, 0, 1, 0, 0);
        chk("boot_state", 32'(bus.Seq_State), 1);
        chk("boot_sel", 32'(bus.PC_Sel), 1);
        chk("boot_imm", bus.Program_Count_Imm, 0);
        chk("boot_fv", 32'(bus.Fetch_Valid), 0);
        tick();
        chk("run_fv", 32'(bus.Fetch_Valid), 1);
        chk("pc0", dut_pc, 32'h0);
        tick();
        tick();
        chk("pc8", dut_pc, 32'h8);
        tick();
        tick();
        chk("pc10", dut_pc, 32'h10);

        // stall hold
        repeat (3) begin
            apply(0, 0, 1, 1, 0, 0);
            chk("stall_run", 32'(bus.Run), 0);
            chk("stall_pc", dut_pc, 32'h10);
            tick();
        end
        apply(0, 0, 0, 1, 0, 0);
        tick();
        chk("pc14", dut_pc, 32'h14);

        // redirect under stall, flush window, ignored second branch
        apply(0, 0, 1, 1, 1, 32'h80);
        chk("br_run", 32'(bus.Run), 1);
        chk("br_imm", bus.Program_Count_Imm, 32'h80);
        chk("br_fv", 32'(bus.Fetch_Valid), 0);
        tick();
        chk("pc80", dut_pc, 32'h80);
        chk("fl1", 32'(bus.Flush), 1);
        chk("model_fl", 32'(m_mode), 3);
        apply(0, 0, 0, 1, 1, 32'h200);
        chk("fl_sel", 32'(bus.PC_Sel), 0);
        chk("fl_imm", bus.Program_Count_Imm, 0);
        tick();
        chk("pc84", dut_pc, 32'h84);
        chk("fl2", 32'(bus.Flush), 1);
        apply(0, 0, 0, 1, 0, 0);
        tick();
        chk("pc88", dut_pc, 32'h88);
        chk("fl_end", 32'(bus.Flush), 0);
        chk("fl_state", 32'(bus.Seq_State), 2);

        // branch beats halt, then halt/resume
        apply(0, 1, 0, 1, 1, 32'h40);
        chk("bh_imm", bus.Program_Count_Imm, 32'h40);
        tick();
        chk("pc40", dut_pc, 32'h40);
        chk("bh_state", 32'(bus.Seq_State), 3);
        apply(0, 1, 0, 0, 0, 0);
        chk("fl_norun", 32'(bus.Run), 0);
        tick();
        tick();
        chk("bh_back", 32'(bus.Seq_State), 2);
        apply(0, 1, 0, 1, 0, 0);
        chk("halt_run", 32'(bus.Run), 0);
        tick();
        chk("halt_state", 32'(bus.Seq_State), 4);
        apply(0, 0, 0, 1, 0, 0);
        tick();
        tick();
        chk("halt_pc", dut_pc, 32'h40);
        apply(1, 1, 0, 1, 0, 0);
        tick();
        chk("halt_stay", 32'(bus.Seq_State), 4);
        apply(1, 0, 0, 1, 0, 0);
        tick();
        chk("resume", 32'(bus.Seq_State), 2);
        apply(0, 0, 0, 1, 0, 0);
        chk("resume_fv", 32'(bus.Fetch_Valid), 1);
        tick();
        chk("pc44", dut_pc, 32'h44);

        // watchdog
        apply(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("wd_pre", 32'(bus.Wdog_Err), 0);
        tick();
        chk("wd_err", 32'(bus.Wdog_Err), 1);
        chk("wd_halt", 32'(bus.Seq_State), 4);
        apply(1, 0, 0, 1, 0, 0);
        tick();
        apply(0, 0, 0, 1, 0, 0);
        tick();
        chk("wd_sticky", 32'(bus.Wdog_Err), 1);
        chk("pc48", dut_pc, 32'h48);

        // async reset mid-flush
        apply(0, 0, 0, 1, 1, 32'h100);
        tick();
        chk("pre_rst_fl", 32'(bus.Flush), 1);
        apply(0, 0, 0, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("ar_run", 32'(bus.Run), 0);
        chk("ar_fl", 32'(bus.Flush), 0);
        chk("ar_err", 32'(bus.Wdog_Err), 0);
        chk("ar_state", 32'(bus.Seq_State), 0);
        tick();
        rst_n = 1'b1;

        // randomized traffic
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 300; i++) begin
                apply($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 7) == 0, $urandom & 32'hffff_fffc);
                tick();
            end
            rst_n = 1'b0;
            #1;
            chk("rnd_rst", 32'(bus.Seq_State), 0);
            tick();
            rst_n = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
